axis_packet_fifo: RTL and testbench

//  Parametrised AXI4-Stream FIFO carrying TDATA/TSTRB/TUSER/TLAST beats between a slave (s_*) and master (m_*) port.

---
 rtl/axis_pkg.sv | 18 +
 rtl/axis_fifo_mem.sv | 26 ++
 rtl/axis_packet_fifo.sv | 139 +++++++++++++
 tb/tb_axis_packet_fifo.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared constants, mode encoding and pointer-width helper
// for the AXI4-Stream packet FIFO.
package axis_pkg;

    localparam int AXIS_DATA_WIDTH = 512;
    localparam int AXIS_USER_WIDTH = 2;

    typedef enum logic {
        AXIS_CUT_THROUGH = 1'b0,
        AXIS_STORE_FWD   = 1'b1
    } axis_fifo_mode_e;

    // Address bits plus one wrap bit
    function automatic int axis_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// Beat storage: register array with synchronous write and
// asynchronous read; contents are deliberately not reset.
module axis_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/axis_packet_fifo.sv
// AXI4-Stream FIFO with cut-through or store-and-forward release,
// occupancy and stored-packet counters, and a sticky oversize flag.
module axis_packet_fifo
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH  = AXIS_DATA_WIDTH,
    parameter int DATA_BYTES  = DATA_WIDTH / 8,
    parameter int USER_WIDTH  = AXIS_USER_WIDTH,
    parameter int DEPTH       = 16,
    parameter int PACKET_MODE = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         s_tdata,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    input  logic                          s_tlast,
    input  logic [DATA_BYTES-1:0]         s_tstrb,
    input  logic [USER_WIDTH-1:0]         s_tuser,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          m_tlast,
    output logic [DATA_BYTES-1:0]         m_tstrb,
    output logic [USER_WIDTH-1:0]         m_tuser,
    output logic [$clog2(DEPTH):0]        level,
    output logic [$clog2(DEPTH):0]        pkt_count,
    output logic                          oversize
);

    localparam int PW = axis_ptr_width(DEPTH);
    localparam int AW = PW - 1;
    localparam int EW = DATA_WIDTH + DATA_BYTES + USER_WIDTH + 1;
    localparam axis_fifo_mode_e MODE =
        (PACKET_MODE != 0) ? AXIS_STORE_FWD : AXIS_CUT_THROUGH;
    localparam logic [PW-1:0] ONE      = PW'(1);
    localparam logic [PW-1:0] FULL_XOR = {1'b1, {AW{1'b0}}};

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic          rel_q, rel_d;
    logic          ovs_q, ovs_d;
    logic          rdy_q, rdy_d;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [EW-1:0] wdata;
    logic [EW-1:0] rdata;

    assign full  = (wr_ptr_q ^ rd_ptr_q) == FULL_XOR;
    assign empty = wr_ptr_q == rd_ptr_q;

    // rdy_q holds s_tready low until the first edge after reset
    assign s_tready = rdy_q & ~full;

    always_comb begin
        m_tvalid = ~empty;
        if (MODE == AXIS_STORE_FWD) begin
            m_tvalid = ~empty & ((pkt_cnt_q != '0) | rel_q);
        end
    end

    assign push = s_tvalid & s_tready;
    assign pop  = m_tvalid & m_tready;

    assign wdata = {s_tlast, s_tuser, s_tstrb, s_tdata};
    assign {m_tlast, m_tuser, m_tstrb, m_tdata} = rdata;

    axis_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (wdata),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rdata)
    );

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        rel_d     = rel_q;
        ovs_d     = ovs_q;
        rdy_d     = 1'b1;

        if (push) begin
            wr_ptr_d = wr_ptr_q + ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ONE;
        end

        unique case ({push & s_tlast, pop & m_tlast})
            2'b10:   pkt_cnt_d = pkt_cnt_q + ONE;
            2'b01:   pkt_cnt_d = pkt_cnt_q - ONE;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase

        // A full FIFO with no complete packet must drain or it deadlocks
        if (MODE == AXIS_STORE_FWD) begin
            if (full && pkt_cnt_q == '0) begin
                rel_d = 1'b1;
                ovs_d = 1'b1;
            end else if (pop && m_tlast) begin
                rel_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pkt_cnt_q <= '0;
            rel_q     <= 1'b0;
            ovs_q     <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
            rel_q     <= rel_d;
            ovs_q     <= ovs_d;
            rdy_q     <= rdy_d;
        end
    end

    assign level     = wr_ptr_q - rd_ptr_q;
    assign pkt_count = pkt_cnt_q;
    assign oversize  = ovs_q;

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Directed and scoreboarded checks for axis_packet_fifo in
// cut-through, store-and-forward and deep-stress configurations.
module tb_axis_packet_fifo;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // a: DEPTH=4 cut-through
    logic [31:0] a_s_tdata, a_m_tdata;
    logic [3:0]  a_s_tstrb, a_m_tstrb;
    logic [1:0]  a_s_tuser, a_m_tuser;
    logic        a_s_tvalid, a_s_tready, a_s_tlast;
    logic        a_m_tvalid, a_m_tready, a_m_tlast, a_ovs;
    logic [2:0]  a_level, a_pkt;

    // b: DEPTH=4 store-and-forward
    logic [31:0] b_s_tdata, b_m_tdata;
    logic [3:0]  b_s_tstrb, b_m_tstrb;
    logic [1:0]  b_s_tuser, b_m_tuser;
    logic        b_s_tvalid, b_s_tready, b_s_tlast;
    logic        b_m_tvalid, b_m_tready, b_m_tlast, b_ovs;
    logic [2:0]  b_level, b_pkt;

    // c: DEPTH=16 cut-through
    logic [31:0] c_s_tdata, c_m_tdata;
    logic [3:0]  c_s_tstrb, c_m_tstrb;
    logic [1:0]  c_s_tuser, c_m_tuser;
    logic        c_s_tvalid, c_s_tready, c_s_tlast;
    logic        c_m_tvalid, c_m_tready, c_m_tlast, c_ovs;
    logic [4:0]  c_level, c_pkt;
    logic [38:0] c_out;

    assign c_out = {c_m_tlast, c_m_tuser, c_m_tstrb, c_m_tdata};

    axis_packet_fifo #(
        .DATA_WIDTH(32), .USER_WIDTH(2), .DEPTH(4), .PACKET_MODE(0)
    ) u_a (
        .clk(clk), .rst(rst),
        .s_tdata(a_s_tdata), .s_tvalid(a_s_tvalid), .s_tready(a_s_tready),
        .s_tlast(a_s_tlast), .s_tstrb(a_s_tstrb), .s_tuser(a_s_tuser),
        .m_tdata(a_m_tdata), .m_tvalid(a_m_tvalid), .m_tready(a_m_tready),
        .m_tlast(a_m_tlast), .m_tstrb(a_m_tstrb), .m_tuser(a_m_tuser),
        .level(a_level), .pkt_count(a_pkt), .oversize(a_ovs)
    );

    axis_packet_fifo #(
        .DATA_WIDTH(32), .USER_WIDTH(2), .DEPTH(4), .PACKET_MODE(1)
    ) u_b (
        .clk(clk), .rst(rst),
        .s_tdata(b_s_tdata), .s_tvalid(b_s_tvalid), .s_tready(b_s_tready),
        .s_tlast(b_s_tlast), .s_tstrb(b_s_tstrb), .s_tuser(b_s_tuser),
        .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid), .m_tready(b_m_tready),
        .m_tlast(b_m_tlast), .m_tstrb(b_m_tstrb), .m_tuser(b_m_tuser),
        .level(b_level), .pkt_count(b_pkt), .oversize(b_ovs)
    );

    axis_packet_fifo #(
        .DATA_WIDTH(32), .USER_WIDTH(2), .DEPTH(16), .PACKET_MODE(0)
    ) u_c (
        .clk(clk), .rst(rst),
        .s_tdata(c_s_tdata), .s_tvalid(c_s_tvalid), .s_tready(c_s_tready),
        .s_tlast(c_s_tlast), .s_tstrb(c_s_tstrb), .s_tuser(c_s_tuser),
        .m_tdata(c_m_tdata), .m_tvalid(c_m_tvalid), .m_tready(c_m_tready),
        .m_tlast(c_m_tlast), .m_tstrb(c_m_tstrb), .m_tuser(c_m_tuser),
        .level(c_level), .pkt_count(c_pkt), .oversize(c_ovs)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_a(input logic [31:0] d, input logic l);
        a_s_tdata  = d;
        a_s_tstrb  = 4'hF;
        a_s_tuser  = 2'b01;
        a_s_tlast  = l;
        a_s_tvalid = 1'b1;
        @(posedge clk); #1;
        a_s_tvalid = 1'b0;
    endtask

    task automatic pop_a(input string tag, input logic [31:0] d);
        chk({tag, "_vld"}, a_m_tvalid, 1);
        chk({tag, "_dat"}, a_m_tdata, d);
        a_m_tready = 1'b1;
        @(posedge clk); #1;
        a_m_tready = 1'b0;
    endtask

    task automatic push_b(input logic [31:0] d, input logic l);
        b_s_tdata  = d;
        b_s_tstrb  = 4'h3;
        b_s_tuser  = 2'b10;
        b_s_tlast  = l;
        b_s_tvalid = 1'b1;
        @(posedge clk); #1;
        b_s_tvalid = 1'b0;
    endtask

    task automatic pop_b(input string tag, input logic [31:0] d,
                         input logic l);
        chk({tag, "_vld"}, b_m_tvalid, 1);
        chk({tag, "_dat"}, b_m_tdata, d);
        chk({tag, "_lst"}, b_m_tlast, l);
        b_m_tready = 1'b1;
        @(posedge clk); #1;
        b_m_tready = 1'b0;
    endtask

    task automatic push_c(input logic [31:0] d, input logic l);
        c_s_tdata  = d;
        c_s_tstrb  = 4'h0;
        c_s_tuser  = 2'b11;
        c_s_tlast  = l;
        c_s_tvalid = 1'b1;
        @(posedge clk); #1;
        c_s_tvalid = 1'b0;
    endtask

    task automatic pop_c(input string tag, input logic [38:0] e);
        chk({tag, "_vld"}, c_m_tvalid, 1);
        chk({tag, "_beat"}, c_out, e);
        c_m_tready = 1'b1;
        @(posedge clk); #1;
        c_m_tready = 1'b0;
    endtask

    initial begin
        logic [38:0] q[$];
        logic [38:0] held;
        logic [38:0] exp;
        logic        hold_v;
        int          sent;
        int          cyc;

        a_s_tdata = '0; a_s_tstrb = '0; a_s_tuser = '0;
        a_s_tvalid = 0; a_s_tlast = 0; a_m_tready = 0;
        b_s_tdata = '0; b_s_tstrb = '0; b_s_tuser = '0;
        b_s_tvalid = 0; b_s_tlast = 0; b_m_tready = 0;
        c_s_tdata = '0; c_s_tstrb = '0; c_s_tuser = '0;
        c_s_tvalid = 0; c_s_tlast = 0; c_m_tready = 0;

        // Reset state
        #3;
        chk("rst_s_tready", a_s_tready, 0);
        chk("rst_m_tvalid", a_m_tvalid, 0);
        chk("rst_level", a_level, 0);
        chk("rst_pkt", a_pkt, 0);
        chk("rst_ovs", b_ovs, 0);
        chk("rst_b_tvalid", b_m_tvalid, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_held_ready", a_s_tready, 0);
        rst = 1'b1;
        chk("rel_ready_before_edge", a_s_tready, 0);
        @(posedge clk); #1;
        chk("rel_ready_after_edge", a_s_tready, 1);
        chk("rel_b_ready", b_s_tready, 1);

        // Cut-through single beat
        a_s_tdata  = 32'hA5A50001;
        a_s_tstrb  = 4'hF;
        a_s_tuser  = 2'b10;
        a_s_tlast  = 1'b1;
        a_s_tvalid = 1'b1;
        @(posedge clk); #1;
        a_s_tvalid = 1'b0;
        chk("ct_tvalid", a_m_tvalid, 1);
        chk("ct_tdata", a_m_tdata, 32'hA5A50001);
        chk("ct_tstrb", a_m_tstrb, 4'hF);
        chk("ct_tuser", a_m_tuser, 2'b10);
        chk("ct_tlast", a_m_tlast, 1);
        chk("ct_level", a_level, 1);
        chk("ct_pkt", a_pkt, 1);
        a_m_tready = 1'b1;
        @(posedge clk); #1;
        a_m_tready = 1'b0;
        chk("ct_pop_level", a_level, 0);
        chk("ct_pop_pkt", a_pkt, 0);
        chk("ct_pop_tvalid", a_m_tvalid, 0);

        // Full: pop-only cycle, then refill
        push_a(32'h10, 0);
        push_a(32'h11, 1);
        push_a(32'h12, 0);
        push_a(32'h13, 0);
        chk("full_level", a_level, 4);
        chk("full_ready", a_s_tready, 0);
        chk("full_pkt", a_pkt, 1);
        a_s_tdata  = 32'h20;
        a_s_tlast  = 1'b1;
        a_s_tvalid = 1'b1;
        a_m_tready = 1'b1;
        @(posedge clk); #1;
        a_m_tready = 1'b0;
        chk("full_pop_only_level", a_level, 3);
        chk("full_pop_head", a_m_tdata, 32'h11);
        chk("full_pop_ready", a_s_tready, 1);
        @(posedge clk); #1;
        a_s_tvalid = 1'b0;
        chk("refill_level", a_level, 4);
        chk("refill_pkt", a_pkt, 2);
        pop_a("drain0", 32'h11);
        pop_a("drain1", 32'h12);
        pop_a("drain2", 32'h13);
        chk("drain3_last", a_m_tlast, 1);
        pop_a("drain3", 32'h20);
        chk("drain_level", a_level, 0);
        chk("drain_pkt", a_pkt, 0);
        chk("drain_tvalid", a_m_tvalid, 0);

        // Store-and-forward
        push_b(32'h1, 0);
        chk("sf_hold1", b_m_tvalid, 0);
        push_b(32'h2, 0);
        chk("sf_hold2", b_m_tvalid, 0);
        push_b(32'h3, 1);
        chk("sf_release", b_m_tvalid, 1);
        chk("sf_pkt", b_pkt, 1);
        chk("sf_strb", b_m_tstrb, 4'h3);
        pop_b("sf0", 32'h1, 0);
        pop_b("sf1", 32'h2, 0);
        pop_b("sf2", 32'h3, 1);
        chk("sf_pkt_drained", b_pkt, 0);
        chk("sf_no_ovs", b_ovs, 0);

        // Oversize packet
        push_b(32'h40, 0);
        push_b(32'h41, 0);
        push_b(32'h42, 0);
        push_b(32'h43, 0);
        chk("ovs_full_level", b_level, 4);
        chk("ovs_not_yet", b_m_tvalid, 0);
        @(posedge clk); #1;
        chk("ovs_tvalid", b_m_tvalid, 1);
        chk("ovs_flag", b_ovs, 1);
        pop_b("ovs0", 32'h40, 0);
        pop_b("ovs1", 32'h41, 0);
        pop_b("ovs2", 32'h42, 0);
        pop_b("ovs3", 32'h43, 0);
        chk("ovs_empty", b_m_tvalid, 0);
        push_b(32'h44, 1);
        pop_b("ovs_tail", 32'h44, 1);
        chk("ovs_sticky", b_ovs, 1);
        push_b(32'h50, 0);
        chk("ovs_rel_cleared", b_m_tvalid, 0);
        chk("ovs_rel_level", b_level, 1);

        // Random stress against a scoreboard
        sent   = 0;
        cyc    = 0;
        hold_v = 1'b0;
        held   = '0;
        while ((sent < 2000 || q.size() != 0) && cyc < 20000) begin
            c_s_tvalid = (sent < 2000) && ($urandom_range(0, 3) != 0);
            c_s_tdata  = $urandom;
            c_s_tstrb  = 4'($urandom_range(0, 15));
            c_s_tuser  = 2'($urandom_range(0, 3));
            c_s_tlast  = ($urandom_range(0, 3) == 0);
            c_m_tready = ($urandom_range(0, 2) != 0);
            #1;
            if (hold_v) begin
                chk("stall_stable", {c_m_tvalid, c_out}, {1'b1, held});
            end
            chk("stress_level", c_level, q.size());
            if (c_m_tvalid && c_m_tready) begin
                if (q.size() == 0) begin
                    chk("stress_underflow", 1, 0);
                end else begin
                    exp = q.pop_front();
                    chk("stress_beat", c_out, exp);
                end
            end
            hold_v = c_m_tvalid && !c_m_tready;
            held   = c_out;
            if (c_s_tvalid && c_s_tready) begin
                q.push_back({c_s_tlast, c_s_tuser, c_s_tstrb, c_s_tdata});
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        c_s_tvalid = 1'b0;
        c_m_tready = 1'b0;
        chk("stress_in_budget", cyc < 20000, 1);
        chk("stress_sent", sent, 2000);

        // Asynchronous reset mid-packet
        push_c(32'h60, 0);
        push_c(32'h61, 0);
        chk("mid_level", c_level, 2);
        chk("mid_tvalid", c_m_tvalid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_tvalid", c_m_tvalid, 0);
        chk("async_level", c_level, 0);
        chk("async_ready", c_s_tready, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_level", c_level, 0);
        chk("post_rst_ready", c_s_tready, 1);
        push_c(32'h70, 0);
        push_c(32'h71, 1);
        chk("post_rst_pkt", c_pkt, 1);
        pop_c("post0", {1'b0, 2'b11, 4'h0, 32'h70});
        pop_c("post1", {1'b1, 2'b11, 4'h0, 32'h71});
        chk("post_rst_drained", c_level, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
